// File: rtl/segment_reader_pkg.sv
`default_nettype none
// ============================================================================
//  segment_reader_pkg
//  Shared seven-segment pattern/code constants, FSM state type, width helper.
//  Revision: 1.0
// ============================================================================
package segment_reader_pkg;

    localparam int SEG_DP = 7;
    localparam int SEG_G  = 6;
    localparam int SEG_F  = 5;
    localparam int SEG_E  = 4;
    localparam int SEG_D  = 3;
    localparam int SEG_C  = 2;
    localparam int SEG_B  = 1;
    localparam int SEG_A  = 0;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_PAT_0    = 7'h3F;
    localparam logic [6:0] SEG_PAT_1    = 7'h06;
    localparam logic [6:0] SEG_PAT_2    = 7'h5B;
    localparam logic [6:0] SEG_PAT_3    = 7'h4F;
    localparam logic [6:0] SEG_PAT_4    = 7'h66;
    localparam logic [6:0] SEG_PAT_5    = 7'h6D;
    localparam logic [6:0] SEG_PAT_6    = 7'h7D;
    localparam logic [6:0] SEG_PAT_7    = 7'h07;
    localparam logic [6:0] SEG_PAT_8    = 7'h7F;
    localparam logic [6:0] SEG_PAT_9    = 7'h67;
    localparam logic [6:0] SEG_PAT_A    = 7'h77;
    localparam logic [6:0] SEG_PAT_B    = 7'h7C;
    localparam logic [6:0] SEG_PAT_C    = 7'h39;
    localparam logic [6:0] SEG_PAT_D    = 7'h5E;
    localparam logic [6:0] SEG_PAT_E    = 7'h79;
    localparam logic [6:0] SEG_PAT_F    = 7'h71;
    localparam logic [6:0] SEG_PAT_DASH = 7'h40;
    localparam logic [6:0] SEG_PAT_OFF  = 7'h00;

    localparam logic [4:0] CODE_DASH = 5'b10000;
    localparam logic [4:0] CODE_OFF  = 5'b10001;

    typedef enum logic [1:0] {
        ST_TRACK  = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/segment_reader_if.sv
`default_nettype none
// ============================================================================
//  segment_reader_if
//  Display bus being monitored plus the decoded readback results.
//  Revision: 1.0
// ============================================================================
interface segment_reader_if
    import segment_reader_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = idx_width(NUM_DIGITS);

    logic [7:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [5*NUM_DIGITS-1:0] code;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   invalid;
    logic                    update;
    logic [IDX_W-1:0]        update_digit;

    modport master (
        output seg_n, an_n,
        input  code, dp, invalid, update, update_digit
    );

    modport slave (
        input  seg_n, an_n,
        output code, dp, invalid, update, update_digit
    );
endinterface
`default_nettype wire

// File: rtl/segment_reader_seg_pattern_decode.sv
`default_nettype none
// ============================================================================
//  seg_pattern_decode
//  Combinational active-high 7-segment pattern to {valid, 5-bit code}.
//  Revision: 1.0
// ============================================================================
module seg_pattern_decode
    import segment_reader_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic       valid_o,
    output logic [4:0] code_o
);

    always_comb begin
        valid_o = 1'b1;
        code_o  = CODE_OFF;
        case (pat_i)
            SEG_PAT_0:    code_o = 5'd0;
            SEG_PAT_1:    code_o = 5'd1;
            SEG_PAT_2:    code_o = 5'd2;
            SEG_PAT_3:    code_o = 5'd3;
            SEG_PAT_4:    code_o = 5'd4;
            SEG_PAT_5:    code_o = 5'd5;
            SEG_PAT_6:    code_o = 5'd6;
            SEG_PAT_7:    code_o = 5'd7;
            SEG_PAT_8:    code_o = 5'd8;
            SEG_PAT_9:    code_o = 5'd9;
            SEG_PAT_A:    code_o = 5'd10;
            SEG_PAT_B:    code_o = 5'd11;
            SEG_PAT_C:    code_o = 5'd12;
            SEG_PAT_D:    code_o = 5'd13;
            SEG_PAT_E:    code_o = 5'd14;
            // "F" and 15 share this pattern; 15 is reported
            SEG_PAT_F:    code_o = 5'd15;
            SEG_PAT_DASH: code_o = CODE_DASH;
            SEG_PAT_OFF:  code_o = CODE_OFF;
            default:      valid_o = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/segment_reader.sv
`default_nettype none
// ============================================================================
//  segment_reader
//  Debounced readback of a multiplexed active-low 7-segment bus into codes.
//  Revision: 1.0
// ============================================================================
module segment_reader
    import segment_reader_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    segment_reader_if.slave  bus
);

    localparam int         IDX_W = idx_width(NUM_DIGITS);
    localparam int         SMP_W = NUM_DIGITS + 8;
    localparam logic [7:0] C_SAT = 8'(STABLE_CYCLES);
    localparam logic [7:0] C_CMT = 8'(STABLE_CYCLES - 2);
    localparam logic [NUM_DIGITS-1:0] C_ONE = NUM_DIGITS'(1);

    logic [SMP_W-1:0]      sample_q, sample_d;
    logic [7:0]            cnt_q, cnt_d;
    state_e                state_q, state_d;
    logic                  update_q;
    logic [IDX_W-1:0]      update_digit_q;

    logic [SMP_W-1:0]      w_in;
    logic                  w_commit;
    logic [NUM_DIGITS-1:0] w_an_s;
    logic [7:0]            w_seg_s;
    logic [NUM_DIGITS-1:0] w_act;
    logic                  w_onehot;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_dec_valid;
    logic [4:0]            w_dec_code;
    logic                  w_new_dp;
    logic [NUM_DIGITS-1:0] w_chg;

    assign w_in    = {bus.an_n, bus.seg_n};
    assign w_an_s  = sample_q[SMP_W-1:8];
    assign w_seg_s = sample_q[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '1;
            cnt_q    <= '0;
            state_q  <= ST_TRACK;
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    // Any input change restarts the count; a commit fires once per stable run
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        w_commit = 1'b0;
        if (w_in != sample_q) begin
            sample_d = w_in;
            cnt_d    = '0;
            state_d  = ST_TRACK;
        end else begin
            if (cnt_q != C_SAT) begin
                cnt_d = cnt_q + 8'd1;
            end
            case (state_q)
                ST_TRACK: begin
                    if (cnt_q == C_CMT) begin
                        state_d  = ST_COMMIT;
                        w_commit = 1'b1;
                    end
                end
                ST_COMMIT: state_d = ST_HOLD;
                ST_HOLD:   state_d = ST_HOLD;
                default:   state_d = ST_TRACK;
            endcase
        end
    end

    assign w_act    = ~w_an_s;
    assign w_onehot = (w_act != '0) && ((w_act & (w_act - C_ONE)) == '0);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_act[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    seg_pattern_decode u_decode (
        .pat_i   (~w_seg_s[SEG_G:SEG_A]),
        .valid_o (w_dec_valid),
        .code_o  (w_dec_code)
    );

    assign w_new_dp = ~w_seg_s[SEG_DP];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [4:0] code_q;
        logic       dp_q;
        logic       inv_q;
        logic [4:0] w_new_code;
        logic       w_wr;

        // Unknown patterns keep the last good code and only raise the flag
        assign w_new_code = w_dec_valid ? w_dec_code : code_q;
        assign w_wr       = w_commit & w_onehot & w_act[i];
        assign w_chg[i]   = w_wr &&
                            ({w_new_code, w_new_dp, ~w_dec_valid} != {code_q, dp_q, inv_q});

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                code_q <= CODE_OFF;
                dp_q   <= 1'b0;
                inv_q  <= 1'b0;
            end else if (w_wr) begin
                code_q <= w_new_code;
                dp_q   <= w_new_dp;
                inv_q  <= ~w_dec_valid;
            end
        end

        assign bus.code[5*i +: 5] = code_q;
        assign bus.dp[i]          = dp_q;
        assign bus.invalid[i]     = inv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_q       <= 1'b0;
            update_digit_q <= '0;
        end else begin
            update_q <= |w_chg;
            if (w_commit && w_onehot) begin
                update_digit_q <= w_idx;
            end
        end
    end

    assign bus.update       = update_q;
    assign bus.update_digit = update_digit_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_reader.sv
`default_nettype none
// ============================================================================
//  tb_segment_reader
//  Directed table-driven bench for segment_reader (4 digits, 4-sample filter).
//  Revision: 1.0
// ============================================================================
module tb_segment_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    segment_reader_if #(.NUM_DIGITS(ND)) bus ();

    segment_reader #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  seg;
        int          hold;
        logic [19:0] code;
        logic [3:0]  dp;
        logic [3:0]  inv;
        int          pulses;
        logic [1:0]  digit;
    } vec_t;

    vec_t vt [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n, output int pulses, output logic [1:0] dig);
        pulses = 0;
        dig    = '0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (bus.update === 1'b1) begin
                pulses++;
                dig = bus.update_digit;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input logic [19:0] c,
                                 input logic [3:0] d, input logic [3:0] v);
        check({tag, " code"},    32'(bus.code),    32'(c));
        check({tag, " dp"},      32'(bus.dp),      32'(d));
        check({tag, " invalid"}, 32'(bus.invalid), 32'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int         p;
        logic [1:0] dg;
        logic [7:0] scan_seg [4];

        total = 0;
        bad   = 0;

        //            an       seg    hold  code        dp    inv   pulses digit
        vt[0]  = '{4'b1110, 8'hA4,  4, 20'h8C622, 4'h0, 4'h0, 1, 2'd0};
        vt[1]  = '{4'b1110, 8'hA4, 10, 20'h8C622, 4'h0, 4'h0, 0, 2'd0};
        vt[2]  = '{4'b1101, 8'h8E,  3, 20'h8C622, 4'h0, 4'h0, 0, 2'd0};
        vt[3]  = '{4'b1111, 8'h8E,  4, 20'h8C622, 4'h0, 4'h0, 0, 2'd0};
        vt[4]  = '{4'b1101, 8'h8E,  4, 20'h8C5E2, 4'h0, 4'h0, 1, 2'd1};
        vt[5]  = '{4'b1100, 8'hC0, 20, 20'h8C5E2, 4'h0, 4'h0, 0, 2'd0};
        vt[6]  = '{4'b0111, 8'h7E,  4, 20'h8C5E2, 4'h8, 4'h8, 1, 2'd3};
        vt[7]  = '{4'b0111, 8'h7E,  6, 20'h8C5E2, 4'h8, 4'h8, 0, 2'd0};
        vt[8]  = '{4'b0111, 8'hBF,  4, 20'h845E2, 4'h0, 4'h0, 1, 2'd3};
        vt[9]  = '{4'b1011, 8'h02,  4, 20'h819E2, 4'h4, 4'h0, 1, 2'd2};
        vt[10] = '{4'b1011, 8'h82,  4, 20'h819E2, 4'h0, 4'h0, 1, 2'd2};
        vt[11] = '{4'b1111, 8'h82,  4, 20'h819E2, 4'h0, 4'h0, 0, 2'd0};
        vt[12] = '{4'b1011, 8'h82,  4, 20'h819E2, 4'h0, 4'h0, 0, 2'd0};

        scan_seg[0] = 8'hF9;
        scan_seg[1] = 8'hA4;
        scan_seg[2] = 8'hBF;
        scan_seg[3] = 8'hFF;

        rst_n      = 1'b0;
        bus.an_n   = 4'b1111;
        bus.seg_n  = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs("reset", 20'h8C631, 4'h0, 4'h0);
        check("reset update",       32'(bus.update),       32'd0);
        check("reset update_digit", 32'(bus.update_digit), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            bus.an_n  = vt[i].an;
            bus.seg_n = vt[i].seg;
            run_cycles(vt[i].hold, p, dg);
            check_outputs($sformatf("v%0d", i), vt[i].code, vt[i].dp, vt[i].inv);
            check($sformatf("v%0d pulses", i), 32'(p), 32'(vt[i].pulses));
            if (vt[i].pulses != 0) begin
                check($sformatf("v%0d update_digit", i), 32'(dg), 32'(vt[i].digit));
            end
        end

        // Reset while update is high clears everything without a clock edge
        bus.an_n  = 4'b1110;
        bus.seg_n = 8'hF9;
        run_cycles(SC, p, dg);
        check("pre-reset pulses", 32'(p), 32'd1);
        check("pre-reset update level", 32'(bus.update), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("async reset", 20'h8C631, 4'h0, 4'h0);
        check("async reset update",       32'(bus.update),       32'd0);
        check("async reset update_digit", 32'(bus.update_digit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(SC - 1, p, dg);
        check("post-reset no early commit", 32'(p), 32'd0);
        run_cycles(1, p, dg);
        check("post-reset commit pulses", 32'(p), 32'd1);
        check("post-reset commit digit",  32'(dg), 32'd0);
        check_outputs("post-reset", 20'h8C621, 4'h0, 4'h0);

        // Reset in the middle of a partial count
        bus.an_n  = 4'b1101;
        bus.seg_n = 8'hA4;
        run_cycles(2, p, dg);
        check("mid-count no pulse", 32'(p), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("mid-count reset", 20'h8C631, 4'h0, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(SC - 1, p, dg);
        check("mid-count discarded", 32'(p), 32'd0);
        run_cycles(1, p, dg);
        check("mid-count recommit pulses", 32'(p), 32'd1);
        check("mid-count recommit digit",  32'(dg), 32'd1);
        check_outputs("mid-count recommit", 20'h8C451, 4'h0, 4'h0);

        // Fresh start, then a full "12-" + off scan
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int pass = 0; pass < 3; pass++) begin
            for (int d = 0; d < 4; d++) begin
                int exp_p;
                exp_p     = (pass == 0 && d < 3) ? 1 : 0;
                bus.an_n  = ~(4'b0001 << d);
                bus.seg_n = scan_seg[d];
                run_cycles(8, p, dg);
                check($sformatf("scan p%0d d%0d pulses", pass, d), 32'(p), 32'(exp_p));
                if (exp_p != 0) begin
                    check($sformatf("scan p%0d d%0d digit", pass, d), 32'(dg), 32'(d));
                end
            end
            check_outputs($sformatf("scan p%0d", pass), 20'h8C041, 4'h0, 4'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
